// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR byte aligner: FSM state encoding,
// default sync byte and the bit-window candidate extractor.
package cdr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } t_align_state;

  localparam logic [7:0] CDR_SYNC_WORD = 8'hBC;

  // Byte starting at bit k of the 16-bit window; bit 0 is the oldest bit.
  function automatic logic [7:0] cdr_candidate(input logic [15:0] window,
                                               input logic [2:0]  k);
    logic [15:0] shifted;
    shifted = window >> k;
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/cdr_sync_search.sv
// Combinational 8-way sync search over a 16-bit window, zero latency,
// no flow control; reports a hit and the lowest matching bit offset.
module cdr_sync_search
  import cdr_pkg::*;
(
  input  logic [15:0] window,
  input  logic [7:0]  sync_word,
  output logic        hit,
  output logic [2:0]  offset
);

  // Descending scan so the lowest matching offset is the one that sticks.
  always_comb begin
    hit    = 1'b0;
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (cdr_candidate(window, 3'(k)) == sync_word) begin
        hit    = 1'b1;
        offset = 3'(k);
      end
    end
  end

endmodule

// File: rtl/cdr_byte_aligner.sv
// Hunts/verifies/locks onto a periodic sync byte and re-emits byte-aligned beats, 1-cycle latency,
// no backpressure (every s_tvalid beat is consumed); CDR_ALIGN_STATS_EN adds lock-loss/sync-error counters.
module cdr_byte_aligner
  import cdr_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = CDR_SYNC_WORD,
  parameter int         FRAME_LEN  = 16,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_tvalid,
  input  logic [7:0]  s_tdata,
  output logic        m_tvalid,
  output logic [7:0]  m_tdata,
  output logic        m_tuser,
  output logic        locked,
  output logic [2:0]  bit_offset
`ifdef CDR_ALIGN_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt,
  output logic [15:0] sync_err_cnt
`endif
);

  localparam int BW = $clog2(FRAME_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [UW-1:0] BAD_LAST  = UW'(UNLOCK_CNT - 1);

  t_align_state  state;
  logic [7:0]    prev_byte;
  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] good_cnt;
  logic [UW-1:0] bad_cnt;

  logic [15:0]   window;
  logic [7:0]    cand;
  logic          hit;
  logic [2:0]    hit_offset;
  logic          sync_pos;
  logic          sync_ok;
  logic          lose;
  logic [BW-1:0] beat_nxt;

  assign window   = {s_tdata, prev_byte};
  assign cand     = cdr_candidate(window, bit_offset);
  assign sync_pos = (beat_cnt == '0);
  assign sync_ok  = (cand == SYNC_WORD);
  assign beat_nxt = (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
  assign lose     = (state == LOCKED) && sync_pos && !sync_ok && (bad_cnt == BAD_LAST);
  assign locked   = (state == LOCKED);

  cdr_sync_search u_search (
    .window    (window),
    .sync_word (SYNC_WORD),
    .hit       (hit),
    .offset    (hit_offset)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= HUNT;
      prev_byte  <= 8'd0;
      beat_cnt   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      bit_offset <= 3'd0;
      m_tvalid   <= 1'b0;
      m_tdata    <= 8'd0;
      m_tuser    <= 1'b0;
    end else if (s_tvalid) begin
      prev_byte <= s_tdata;
      // Only beats seen with the state register already LOCKED are emitted.
      m_tvalid  <= (state == LOCKED);
      case (state)
        HUNT: begin
          if (hit) begin
            bit_offset <= hit_offset;
            beat_cnt   <= BW'(1);
            good_cnt   <= GW'(1);
            bad_cnt    <= '0;
            state      <= (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          beat_cnt <= beat_nxt;
          if (sync_pos) begin
            if (sync_ok) begin
              good_cnt <= good_cnt + 1'b1;
              if (good_cnt == GOOD_LAST) begin
                bad_cnt <= '0;
                state   <= LOCKED;
              end
            end else begin
              good_cnt <= '0;
              state    <= HUNT;
            end
          end
        end
        LOCKED: begin
          beat_cnt <= beat_nxt;
          m_tdata  <= cand;
          m_tuser  <= sync_pos && !lose;
          if (sync_pos) begin
            if (sync_ok) begin
              bad_cnt <= '0;
            end else if (lose) begin
              bad_cnt  <= '0;
              good_cnt <= '0;
              state    <= HUNT;
            end else begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end else begin
      m_tvalid <= 1'b0;
    end
  end

`ifdef CDR_ALIGN_STATS_EN
  logic sync_err;
  assign sync_err = ((state == VERIFY) || (state == LOCKED)) && sync_pos && !sync_ok;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_loss_cnt <= 16'd0;
      sync_err_cnt  <= 16'd0;
    end else if (s_tvalid) begin
      if (lose && (lock_loss_cnt != 16'hFFFF)) lock_loss_cnt <= lock_loss_cnt + 16'd1;
      if (sync_err && (sync_err_cnt != 16'hFFFF)) sync_err_cnt <= sync_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdr_byte_aligner.sv
// Directed bench for cdr_byte_aligner: aligned and 5-bit shifted streams, sync corruption,
// VERIFY failure, mid-frame sync byte, gappy valid and async reset (stats checked when CDR_ALIGN_STATS_EN).
module tb_cdr_byte_aligner;

  localparam logic [7:0] SYNC = 8'hBC;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_tvalid;
  logic [7:0]  s_tdata;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tuser;
  logic        locked;
  logic [2:0]  bit_offset;
`ifdef CDR_ALIGN_STATS_EN
  logic [15:0] lock_loss_cnt;
  logic [15:0] sync_err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic       sh5;
  logic [7:0] last_o;
  logic [7:0] exp_d;
  logic [7:0] pay [16];

  always #5 aclk = ~aclk;

  cdr_byte_aligner #(
    .SYNC_WORD  (SYNC),
    .FRAME_LEN  (16),
    .LOCK_CNT   (3),
    .UNLOCK_CNT (4)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tuser    (m_tuser),
    .locked     (locked),
    .bit_offset (bit_offset)
`ifdef CDR_ALIGN_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .sync_err_cnt  (sync_err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sends original-stream byte n; with sh5 the bit stream is delayed by 5 bits.
  task automatic sb(input int n, input bit bad_sync, input bit mid_bc);
    logic [7:0] o;
    logic [7:0] din;
    if (n % 16 == 0) o = bad_sync ? 8'h00 : SYNC;
    else if (mid_bc) o = SYNC;
    else o = pay[n % 16];
    din    = sh5 ? {o[2:0], last_o[7:3]} : o;
    exp_d  = last_o;
    last_o = o;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = din;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tdata  = SYNC;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk({ph, "_rst_m_tvalid"}, 16'(m_tvalid), 16'd0);
    chk({ph, "_rst_m_tdata"}, 16'(m_tdata), 16'd0);
    chk({ph, "_rst_m_tuser"}, 16'(m_tuser), 16'd0);
    chk({ph, "_rst_locked"}, 16'(locked), 16'd0);
    chk({ph, "_rst_bit_offset"}, 16'(bit_offset), 16'd0);
`ifdef CDR_ALIGN_STATS_EN
    chk({ph, "_rst_lock_loss"}, lock_loss_cnt, 16'd0);
    chk({ph, "_rst_sync_err"}, sync_err_cnt, 16'd0);
`endif
  endtask

  initial begin
    pay = '{8'hBC, 8'h01, 8'h02, 8'h04, 8'h05, 8'h08, 8'h0A, 8'h10,
            8'h12, 8'h14, 8'h15, 8'h20, 8'h41, 8'h84, 8'hA5, 8'h55};
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    sh5      = 1'b0;
    last_o   = 8'h00;
    exp_d    = 8'h00;
    repeat (2) @(posedge aclk);
    #1;
    chk_reset_outputs("init");
    @(negedge aclk);
    aresetn = 1'b1;

    // Aligned stream: hits at beats 1, 17, 33 -> locked after beat 33.
    for (int n = 0; n < 33; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("a_locked_pre", 16'(locked), 16'd0);
      chk("a_m_tvalid_pre", 16'(m_tvalid), 16'd0);
    end
    sb(33, 1'b0, 1'b0);
    chk("a_locked_rise", 16'(locked), 16'd1);
    chk("a_lock_beat_not_output", 16'(m_tvalid), 16'd0);
    chk("a_bit_offset", 16'(bit_offset), 16'd0);
    for (int n = 34; n < 82; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("a_m_tvalid", 16'(m_tvalid), 16'd1);
      chk("a_m_tdata", 16'(m_tdata), 16'(exp_d));
      chk("a_m_tuser", 16'(m_tuser), 16'(((n - 1) % 16) == 0));
    end

    // Reset mid-frame while locked, then the same stream shifted by 5 bits.
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 chk_reset_outputs("b");
    @(negedge aclk);
    aresetn = 1'b1;
    sh5     = 1'b1;
    last_o  = 8'h00;
    for (int n = 0; n < 33; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("b_locked_pre", 16'(locked), 16'd0);
    end
    sb(33, 1'b0, 1'b0);
    chk("b_locked_rise", 16'(locked), 16'd1);
    chk("b_bit_offset", 16'(bit_offset), 16'd5);
    for (int n = 34; n < 66; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("b_m_tvalid", 16'(m_tvalid), 16'd1);
      chk("b_m_tdata", 16'(m_tdata), 16'(exp_d));
      chk("b_m_tuser", 16'(m_tuser), 16'(((n - 1) % 16) == 0));
    end

    // Syncs 80/96/112/128 corrupted (seen at beats 81/97/113/129); sync byte mid-frame at 100.
    for (int n = 66; n < 130; n++) begin
      sb(n, (n >= 80) && (n <= 128), n == 100);
      chk("c_m_tvalid", 16'(m_tvalid), 16'd1);
      chk("c_m_tdata", 16'(m_tdata), 16'(exp_d));
      chk("c_m_tuser", 16'(m_tuser), 16'((((n - 1) % 16) == 0) && (n != 129)));
      chk("c_locked", 16'(locked), 16'(n < 129));
`ifdef CDR_ALIGN_STATS_EN
      if (n == 101) chk("c_sync_err_mid_bc", sync_err_cnt, 16'd2);
      if (n == 113) chk("c_sync_err_3", sync_err_cnt, 16'd3);
      if (n == 129) begin
        chk("c_sync_err_4", sync_err_cnt, 16'd4);
        chk("c_lock_loss_1", lock_loss_cnt, 16'd1);
      end
`endif
    end
    for (int n = 130; n < 178; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("c_relock", 16'(locked), 16'(n == 177));
      chk("c_relock_m_tvalid", 16'(m_tvalid), 16'd0);
    end
`ifdef CDR_ALIGN_STATS_EN
    chk("c_lock_loss_hold", lock_loss_cnt, 16'd1);
`endif

    // Gappy valid while locked: idle cycles emit nothing and hold data.
    for (int n = 178; n < 186; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("e_m_tvalid", 16'(m_tvalid), 16'd1);
      chk("e_m_tdata", 16'(m_tdata), 16'(exp_d));
      chk("e_m_tuser", 16'(m_tuser), 16'(((n - 1) % 16) == 0));
      idle();
      chk("e_idle_m_tvalid", 16'(m_tvalid), 16'd0);
      chk("e_idle_m_tdata_hold", 16'(m_tdata), 16'(exp_d));
      chk("e_idle_locked", 16'(locked), 16'd1);
    end
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 chk_reset_outputs("e");
    @(negedge aclk);
    aresetn = 1'b1;
    last_o  = 8'h00;
    for (int n = 0; n < 34; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("e_relock", 16'(locked), 16'(n == 33));
      idle();
    end
    chk("e_bit_offset", 16'(bit_offset), 16'd5);
    sb(34, 1'b0, 1'b0);
    chk("e_first_m_tvalid", 16'(m_tvalid), 16'd1);
    chk("e_first_m_tdata", 16'(m_tdata), 16'(exp_d));
    chk("e_first_m_tuser", 16'(m_tuser), 16'd0);

    // VERIFY failure: first hit at offset 5, 2nd sync corrupted, then aligned stream re-latches 0.
    @(negedge aclk);
    #2 aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    sh5     = 1'b1;
    last_o  = 8'h00;
    for (int n = 0; n < 34; n++) begin
      if (n == 20) sh5 = 1'b0;
      sb(n, n == 16, 1'b0);
      chk("d_locked_never", 16'(locked), 16'd0);
      if (n == 1) chk("d_bit_offset_first", 16'(bit_offset), 16'd5);
      if (n == 17) begin
        chk("d_bit_offset_stable", 16'(bit_offset), 16'd5);
`ifdef CDR_ALIGN_STATS_EN
        chk("d_sync_err_verify", sync_err_cnt, 16'd1);
`endif
      end
    end
    chk("d_bit_offset_relatch", 16'(bit_offset), 16'd0);
    for (int n = 34; n < 66; n++) begin
      sb(n, 1'b0, 1'b0);
      chk("d_relock", 16'(locked), 16'(n == 65));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
